// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the UART MMIO controller.
//   - Word offsets of the memory-mapped registers (addr[7:0]).
//   - Bit positions inside the status word.
//   - status_word(): assembles the status register from FIFO flags.
package mmio_pkg;

  localparam logic [7:0] MMIO_STATUS = 8'h00;
  localparam logic [7:0] MMIO_RX     = 8'h04;
  localparam logic [7:0] MMIO_TX     = 8'h08;
  localparam logic [7:0] MMIO_CYC    = 8'h10;
  localparam logic [7:0] MMIO_INST   = 8'h14;
  localparam logic [7:0] MMIO_CLR    = 8'h18;

  localparam int STAT_TX_NFULL  = 0;
  localparam int STAT_RX_NEMPTY = 1;

  function automatic logic [31:0] status_word(input logic tx_nfull, input logic rx_nempty);
    logic [31:0] w;
    w                 = 32'h0000_0000;
    w[STAT_TX_NFULL]  = tx_nfull;
    w[STAT_RX_NEMPTY] = rx_nempty;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
//   clk, rst (sync, active-low) | push, din : write side
//   pop, dout (head)                         : read side
//   full, empty                              : flags from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Push while full and pop while empty are ignored internally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO window (addr[31]=1) between the CPU and the UART.
//   clk, rst (sync, active-low)
//   addr, wdata, we, re  : execute-stage load/store
//   inst_retire          : one pulse per retired instruction
//   rdata                : load data, one cycle after the load
//   tx_data/valid/ready  : TX FIFO head to UART transmitter
//   rx_data/valid/ready  : UART receiver into RX FIFO
module uart_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic        wr_s, rd_s, clr_s, unused_s;
  logic [7:0]  off_s;
  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]  rx_dout_s;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] inst_q, inst_d;
  logic        rx_en_q;

  // A write wins over a simultaneous read, so the read is masked by we.
  assign wr_s     = addr[31] & we;
  assign rd_s     = addr[31] & re & ~we;
  assign off_s    = addr[7:0];
  assign clr_s    = wr_s & (off_s == MMIO_CLR);
  assign unused_s = ^{addr[30:8], wdata[31:8]};

  assign tx_push_s = wr_s & (off_s == MMIO_TX) & ~tx_full_s;
  assign tx_pop_s  = ~tx_empty_s & tx_ready;
  assign rx_push_s = rx_valid & rx_ready;
  assign rx_pop_s  = rd_s & (off_s == MMIO_RX) & ~rx_empty_s;

  assign tx_valid = ~tx_empty_s;
  // rx_en_q holds rx_ready low through reset and releases it one edge later.
  assign rx_ready = rx_en_q & ~rx_full_s;
  assign rdata    = rdata_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (wdata[7:0]),
    .dout  (tx_data),
    .full  (tx_full_s),
    .empty (tx_empty_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (rx_data),
    .dout  (rx_dout_s),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  // Read mux; status and counters are sampled before the edge.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      case (off_s)
        MMIO_STATUS: rdata_d = status_word(~tx_full_s, ~rx_empty_s);
        MMIO_RX:     rdata_d = {24'h00_0000, (rx_empty_s ? 8'h00 : rx_dout_s)};
        MMIO_CYC:    rdata_d = cyc_q;
        MMIO_INST:   rdata_d = inst_q;
        default:     rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Counter next-state; a clear overrides this cycle's increments.
  always_comb begin
    cyc_d  = cyc_q;
    inst_d = inst_q;
    if (clr_s) begin
      cyc_d  = 32'h0000_0000;
      inst_d = 32'h0000_0000;
    end else begin
      cyc_d  = cyc_q + 32'h0000_0001;
      inst_d = inst_q + {31'h0000_0000, inst_retire};
    end
  end

  // Read data, counters and RX enable registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 32'h0000_0000;
      cyc_q   <= 32'h0000_0000;
      inst_q  <= 32'h0000_0000;
      rx_en_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
      rx_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        inst_retire = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic        pend = 1'b0;

  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .inst_retire(inst_retire), .rdata(rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] e);
    addr = a; re = 1'b1; we = 1'b0;
    if (a[31]) rd_q.push_back(e);
    step();
    re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    step();
    we = 1'b0;
  endtask

  // Monitor: rdata one cycle after each selected load, zero otherwise; TX bytes on handshake.
  always @(negedge clk) begin
    if (pend) begin
      if (rd_q.size() == 0) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL rdata_unexpected: got 0x%08h expected no load", rdata);
      end else begin
        chk("rdata", rdata, rd_q.pop_front());
      end
    end else begin
      chk("rdata_idle", rdata, 32'h0);
    end
    pend = re & ~we & addr[31];
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL tx_unexpected: got 0x%02h expected none", tx_data);
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset
    repeat (3) step();
    @(negedge clk);
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_rx_ready", {31'h0, rx_ready}, 32'h0);
    step();
    rst = 1'b1;
    repeat (10) step();
    do_load(32'h8000_0010, 32'd10);
    chk("rx_ready_after_reset", {31'h0, rx_ready}, 32'h1);
    do_load(32'h8000_0000, 32'h1);
    do_load(32'h8000_000C, 32'h0);
    do_load(32'h0000_0010, 32'h0);

    // Store outside the window must not reach TX
    do_store(32'h0000_0008, 32'h99);
    chk("low_store_tx_valid", {31'h0, tx_valid}, 32'h0);

    // Two TX bytes, held then drained
    do_store(32'h8000_0008, 32'h41);
    do_store(32'h8000_0008, 32'h42);
    tx_q.push_back(8'h41); tx_q.push_back(8'h42);
    chk("tx_valid_held", {31'h0, tx_valid}, 32'h1);
    chk("tx_head_held", {24'h0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    repeat (3) step();
    chk("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Fill TX, overflow byte dropped
    for (int i = 0; i < 8; i++) begin
      do_store(32'h8000_0008, 32'h50 + i);
      tx_q.push_back(8'h50 + 8'(i));
    end
    do_load(32'h8000_0000, 32'h0);
    do_store(32'h8000_0008, 32'hEE);
    do_load(32'h8000_0000, 32'h0);
    tx_ready = 1'b1;
    repeat (10) step();
    chk("tx_valid_after_drain8", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Fill RX
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i); rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    chk("rx_ready_full", {31'h0, rx_ready}, 32'h0);
    do_load(32'h8000_0000, 32'h3);
    for (int i = 0; i < 8; i++) do_load(32'h8000_0004, 32'h10 + i);
    do_load(32'h8000_0004, 32'h0);
    do_load(32'h8000_0000, 32'h1);

    // Simultaneous RX push and pop at count 3
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h20 + 8'(i); rx_valid = 1'b1;
      step();
    end
    rx_data = 8'h23; rx_valid = 1'b1;
    do_load(32'h8000_0004, 32'h20);
    rx_valid = 1'b0;
    do_load(32'h8000_0000, 32'h3);
    do_load(32'h8000_0004, 32'h21);
    do_load(32'h8000_0004, 32'h22);
    do_load(32'h8000_0004, 32'h23);
    do_load(32'h8000_0004, 32'h0);

    // Counters and clear
    inst_retire = 1'b1;
    repeat (5) step();
    inst_retire = 1'b0;
    do_load(32'h8000_0014, 32'd5);
    inst_retire = 1'b1;
    do_store(32'h8000_0018, 32'h0);
    inst_retire = 1'b0;
    do_load(32'h8000_0010, 32'd0);
    do_load(32'h8000_0014, 32'd0);
    do_load(32'h8000_0010, 32'd2);

    repeat (3) step();
    chk("rd_queue_empty", rd_q.size(), 32'h0);
    chk("tx_queue_empty", tx_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
